pwm_audio_out: RTL

- Consumer end of the mixed-sample path: accepts the saturated 8-bit mixed sample and drives it off-chip as a single-bit PWM stream.
- Mixed sample enters through a one-entry pending buffer, then loads into the active duty register only at PWM period boundaries, so the duty never changes mid-period.
- Flags overrun (sample overwritten before use) and repeats the last duty on underrun.

---
 rtl/pwm_audio_out_if.sv | 25 ++
 rtl/pwm_audio_out.sv | 124 ++++++++++++
 2 files changed

// File: rtl/pwm_audio_out_if.sv
// Sample-path bundle between the mixer (master) and the PWM output stage (slave).
// Carries the mixed sample strobe, overrun clear, and buffer status back to the mixer.
interface pwm_audio_out_if;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       clr_overrun;
    logic       pending_full;
    logic       overrun;

    modport master (
        output sample_in,
        output sample_valid,
        output clr_overrun,
        input  pending_full,
        input  overrun
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        input  clr_overrun,
        output pending_full,
        output overrun
    );
endinterface

// File: rtl/pwm_audio_out.sv
// Single-bit PWM audio output: one-entry pending sample buffer feeding a duty register
// that only reloads at period boundaries, with sticky overrun and repeat-on-underrun.
module pwm_audio_out #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    pwm_audio_out_if.slave   smp,
    output logic             pwm_out,
    output logic             period_done
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [DivW-1:0] div_q, div_d;
    logic [7:0]      duty_q, duty_d;
    logic [7:0]      pending_q, pending_d;
    logic            pending_full_q, pending_full_d;
    logic            overrun_q, overrun_d;
    logic            pwm_q, pwm_d;
    logic            period_done_q, period_done_d;
    logic            consume;
    logic            tick;

    assign tick = (div_q == DivLast);

    // Sequencing: FSM/counter decide whether the buffer is consumed; the write port
    // then layers on top so a coincident write refills the slot just emptied.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        div_d          = div_q;
        duty_d         = duty_q;
        period_done_d  = 1'b0;
        consume        = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = 8'd0;
                div_d = '0;
                if (en) begin
                    state_d = StRun;
                    if (pending_full_q) begin
                        consume = 1'b1;
                    end else begin
                        duty_d = 8'd0;
                    end
                end
            end
            StRun: begin
                if (!en) begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                    div_d   = '0;
                end else if (tick) begin
                    div_d = '0;
                    if (cnt_q == 8'd255) begin
                        cnt_d         = 8'd0;
                        period_done_d = 1'b1;
                        consume       = pending_full_q;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        if (consume) begin
            duty_d         = pending_q;
            pending_full_d = 1'b0;
        end
        if (smp.sample_valid) begin
            pending_d      = smp.sample_in;
            pending_full_d = 1'b1;
        end

        // Set has priority over clear.
        overrun_d = (overrun_q & ~smp.clr_overrun) |
                    (smp.sample_valid & pending_full_q & ~consume);

        pwm_d = (state_q == StRun) && (cnt_q < duty_q);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q        <= StIdle;
            cnt_q          <= 8'd0;
            div_q          <= '0;
            duty_q         <= 8'd0;
            pending_q      <= 8'd0;
            pending_full_q <= 1'b0;
            overrun_q      <= 1'b0;
            pwm_q          <= 1'b0;
            period_done_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            div_q          <= div_d;
            duty_q         <= duty_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            overrun_q      <= overrun_d;
            pwm_q          <= pwm_d;
            period_done_q  <= period_done_d;
        end
    end

    assign pwm_out          = pwm_q;
    assign period_done      = period_done_q;
    assign smp.pending_full = pending_full_q;
    assign smp.overrun      = overrun_q;

endmodule
